// File: rtl/umi_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : umi_initiator
//  Purpose  : Requester-side UMI bridge. Turns a local read/write request
//             port into UMI request packets on tx0 and matches returning
//             read-response packets on rx0. Writes are posted; one read may
//             be outstanding at a time, guarded by a response timeout.
//  Revision : 1.0  initial release
// ============================================================================
module umi_initiator #(
   parameter int          AW      = 16,
   parameter int          DW      = 64,
   parameter logic [63:0] SRCADDR = 64'h0000_0000_0001_0000,
   parameter int          TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          nreset,
   // local request port
   input  logic          req_valid,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          req_ready,
   // local read completion
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   // outbound UMI requests
   output logic          tx0_umi_valid,
   output logic [255:0]  tx0_umi_packet,
   input  logic          tx0_umi_ready,
   // inbound UMI responses
   input  logic          rx0_umi_valid,
   input  logic [255:0]  rx0_umi_packet,
   output logic          rx0_umi_ready,
   // diagnostics
   output logic [7:0]    drop_count
);

   localparam logic [7:0] OP_WRITE     = 8'h01;
   localparam logic [7:0] OP_READ      = 8'h08;
   localparam logic [7:0] OP_READ_RESP = 8'h03;

   // Timer only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int            TW    = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]    state_q,     state_d;
   logic          is_read_q,   is_read_d;
   logic [255:0]  pkt_q,       pkt_d;
   logic [TW-1:0] timer_q,     timer_d;
   logic          req_ready_q, req_ready_d;
   logic          tx_valid_q,  tx_valid_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q,   rsp_err_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rx_ready_q;
   logic [7:0]    drop_q,      drop_d;

   logic [255:0]  req_pkt;
   logic          rx_fire;
   logic          rx_match;
   logic          unused_rx_bits;

   // Inbound qualification: a response matches only on opcode and dstaddr.
   assign rx_fire  = rx0_umi_valid && rx_ready_q;
   assign rx_match = (rx0_umi_packet[7:0] == OP_READ_RESP) &&
                     (rx0_umi_packet[95:32] == SRCADDR);

   // Reserved and beyond-data inbound bits carry no meaning here.
   assign unused_rx_bits = ^{rx0_umi_packet[31:8], rx0_umi_packet[255:160+DW]};

   // Assemble the outbound request packet from the local request fields.
   always_comb begin
      req_pkt          = '0;
      req_pkt[7:0]     = req_write ? OP_WRITE : OP_READ;
      req_pkt[95:32]   = 64'(req_addr);
      req_pkt[159:96]  = SRCADDR;
      if (req_write) begin
         req_pkt[160 +: DW] = req_wdata;
      end
   end

   // Next-state logic for the request/response sequencer and drop counter.
   always_comb begin
      state_d     = state_q;
      is_read_d   = is_read_q;
      pkt_d       = pkt_q;
      timer_d     = timer_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      drop_d      = drop_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               pkt_d     = req_pkt;
               is_read_d = !req_write;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_valid_q && tx0_umi_ready) begin
               if (is_read_q) begin
                  state_d = ST_WAIT;
                  timer_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            // A match on the timeout cycle still completes successfully.
            if (rx_fire && rx_match) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rx0_umi_packet[160 +: DW];
               state_d     = ST_IDLE;
            end else if (timer_q == TLAST) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Everything accepted that is not the awaited response is discarded.
      if (rx_fire && !((state_q == ST_WAIT) && rx_match) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      // Handshake outputs are registered copies of the upcoming state.
      req_ready_d = (state_d == ST_IDLE);
      tx_valid_d  = (state_d == ST_SEND);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q     <= ST_IDLE;
         is_read_q   <= 1'b0;
         pkt_q       <= '0;
         timer_q     <= '0;
         req_ready_q <= 1'b0;
         tx_valid_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         rx_ready_q  <= 1'b0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         is_read_q   <= is_read_d;
         pkt_q       <= pkt_d;
         timer_q     <= timer_d;
         req_ready_q <= req_ready_d;
         tx_valid_q  <= tx_valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         rx_ready_q  <= 1'b1;
         drop_q      <= drop_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign tx0_umi_valid  = tx_valid_q;
   assign tx0_umi_packet = pkt_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_err        = rsp_err_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rx0_umi_ready  = rx_ready_q;
   assign drop_count     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_umi_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_umi_initiator
//  Purpose  : Scoreboard bench for umi_initiator. Drivers push expected tx
//             packets and read completions into queues; negedge monitors pop
//             and compare whenever the DUT presents a handshake or pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_umi_initiator;

   localparam int          AW      = 16;
   localparam int          DW      = 64;
   localparam int          TIMEOUT = 8;
   localparam logic [63:0] SRC     = 64'h0000_0000_0001_0000;

   logic          clk;
   logic          nreset;
   logic          req_valid;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          tx0_umi_valid;
   logic [255:0]  tx0_umi_packet;
   logic          tx0_umi_ready;
   logic          rx0_umi_valid;
   logic [255:0]  rx0_umi_packet;
   logic          rx0_umi_ready;
   logic [7:0]    drop_count;

   umi_initiator #(
      .AW      (AW),
      .DW      (DW),
      .SRCADDR (SRC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .nreset         (nreset),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .tx0_umi_valid  (tx0_umi_valid),
      .tx0_umi_packet (tx0_umi_packet),
      .tx0_umi_ready  (tx0_umi_ready),
      .rx0_umi_valid  (rx0_umi_valid),
      .rx0_umi_packet (rx0_umi_packet),
      .rx0_umi_ready  (rx0_umi_ready),
      .drop_count     (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int errors   = 0;
   int tx_count = 0;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          at;
   } rsp_t;

   logic [255:0] tx_q[$];
   rsp_t         rsp_q[$];

   function automatic logic [255:0] mkpkt(input logic [7:0] op, input logic [63:0] dst,
                                          input logic [63:0] src, input logic [63:0] d);
      logic [255:0] p;
      p          = '0;
      p[7:0]     = op;
      p[95:32]   = dst;
      p[159:96]  = src;
      p[223:160] = d;
      return p;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_rsp(input logic [63:0] d, input logic e, input int at);
      rsp_t r;
      r.data = d;
      r.err  = e;
      r.at   = at;
      rsp_q.push_back(r);
   endtask

   // Monitor: every outbound handshake must match the next expected packet.
   always @(negedge clk) begin
      if (nreset && tx0_umi_valid && tx0_umi_ready) begin
         tx_count++;
         if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got packet %h expected none", tx0_umi_packet);
         end else begin
            chk("tx_packet", tx0_umi_packet, tx_q.pop_front());
         end
      end
   end

   // Monitor: every completion pulse must match the next expected completion.
   always @(negedge clk) begin
      rsp_t e;
      if (rsp_valid) begin
         if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got rdata %h err %0d expected no response",
                     rsp_rdata, rsp_err);
         end else begin
            e = rsp_q.pop_front();
            chk("rsp_rdata", 256'(rsp_rdata), 256'(e.data));
            chk("rsp_err",   256'(rsp_err),   256'(e.err));
            chk("rsp_cycle", 256'(cyc),       256'(e.at));
         end
      end
   end

   // Issue one local request; returns the negedge cycle in which it was seen accepted.
   task automatic do_req(input logic wr, input logic [15:0] addr, input logic [63:0] wd,
                         output int acc_cyc);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      tx_q.push_back(mkpkt(wr ? 8'h01 : 8'h08, {48'h0, addr}, SRC, wr ? wd : 64'h0));
      acc_cyc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            acc_cyc = cyc;
            break;
         end
      end
      if (acc_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL req_accept: got no req_ready within 50 cycles expected acceptance");
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = '0;
   endtask

   // Wait for the next outbound handshake (seen at negedge before the edge).
   task automatic wait_tx_hs(output int hs_cyc);
      hs_cyc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx0_umi_valid && tx0_umi_ready) begin
            hs_cyc = cyc;
            break;
         end
      end
      if (hs_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL tx_handshake: got none within 50 cycles expected a packet");
      end
   endtask

   // Present one inbound packet for a single cycle.
   task automatic send_rx(input logic [7:0] op, input logic [63:0] dst, input logic [63:0] d,
                          input logic expect_rsp);
      @(posedge clk); #1;
      rx0_umi_valid  = 1'b1;
      rx0_umi_packet = mkpkt(op, dst, 64'h0, d);
      if (expect_rsp) push_rsp(d, 1'b0, cyc + 1);
      @(negedge clk);
      chk("rx_ready", 256'(rx0_umi_ready), 256'(1));
      @(posedge clk); #1;
      rx0_umi_valid  = 1'b0;
      rx0_umi_packet = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 256'(req_ready),     256'(0));
      chk({tag, "_tx_valid"},  256'(tx0_umi_valid), 256'(0));
      chk({tag, "_tx_packet"}, tx0_umi_packet,      256'(0));
      chk({tag, "_rsp_valid"}, 256'(rsp_valid),     256'(0));
      chk({tag, "_rsp_err"},   256'(rsp_err),       256'(0));
      chk({tag, "_rsp_rdata"}, 256'(rsp_rdata),     256'(0));
      chk({tag, "_rx_ready"},  256'(rx0_umi_ready), 256'(0));
      chk({tag, "_drop"},      256'(drop_count),    256'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int a;
      int h;
      logic [255:0] bp_pkt;

      nreset         = 1'b0;
      req_valid      = 1'b0;
      req_write      = 1'b0;
      req_addr       = '0;
      req_wdata      = '0;
      tx0_umi_ready  = 1'b1;
      rx0_umi_valid  = 1'b0;
      rx0_umi_packet = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      nreset = 1'b1;
      @(negedge clk);
      chk("release_ready_low", 256'(req_ready), 256'(0));
      @(negedge clk);
      chk("release_ready_high", 256'(req_ready), 256'(1));
      chk("release_rx_ready", 256'(rx0_umi_ready), 256'(1));

      // Posted write: req_ready low one cycle, high again two cycles after accept
      do_req(1'b1, 16'h0040, 64'hDEAD_BEEF_0000_0001, a);
      @(negedge clk);
      chk("wr_ready_low", 256'(req_ready), 256'(0));
      @(negedge clk);
      chk("wr_ready_back", 256'(req_ready), 256'(1));

      // Read round trip, response three cycles after tx handshake
      do_req(1'b0, 16'h0040, 64'h0, a);
      wait_tx_hs(h);
      repeat (2) @(posedge clk);
      send_rx(8'h03, SRC, 64'h1234, 1'b1);
      repeat (2) @(negedge clk);
      chk("rd_rsp_done", 256'(rsp_q.size()), 256'(0));
      chk("rd_drop", 256'(drop_count), 256'(0));

      // Backpressure: packet held stable for 5 cycles
      @(posedge clk); #1;
      tx0_umi_ready = 1'b0;
      bp_pkt = mkpkt(8'h01, 64'h100, SRC, 64'h0123_4567_89AB_CDEF);
      do_req(1'b1, 16'h0100, 64'h0123_4567_89AB_CDEF, a);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",  256'(tx0_umi_valid), 256'(1));
         chk("bp_packet", tx0_umi_packet, bp_pkt);
      end
      @(posedge clk); #1;
      tx0_umi_ready = 1'b1;
      wait_tx_hs(h);
      @(negedge clk);
      chk("bp_valid_drop", 256'(tx0_umi_valid), 256'(0));
      chk("bp_tx_count", 256'(tx_count), 256'(3));

      // Filtering: WRITE opcode and wrong dstaddr dropped, correct response kept
      do_req(1'b0, 16'h0200, 64'h0, a);
      wait_tx_hs(h);
      send_rx(8'h01, SRC, 64'h1111, 1'b0);
      send_rx(8'h03, SRC ^ 64'h1, 64'h2222, 1'b0);
      send_rx(8'h03, SRC, 64'hCAFE_F00D_0000_0055, 1'b1);
      repeat (2) @(negedge clk);
      chk("filt_drop", 256'(drop_count), 256'(2));
      chk("filt_rsp_done", 256'(rsp_q.size()), 256'(0));

      // Timeout: error completion 8 cycles after handshake, late response dropped
      do_req(1'b0, 16'h0300, 64'h0, a);
      wait_tx_hs(h);
      push_rsp(64'h0, 1'b1, h + 9);
      repeat (9) @(negedge clk);
      @(posedge clk);
      send_rx(8'h03, SRC, 64'h5555, 1'b0);
      @(negedge clk);
      chk("to_rsp_done", 256'(rsp_q.size()), 256'(0));
      chk("to_late_drop", 256'(drop_count), 256'(3));
      chk("to_ready", 256'(req_ready), 256'(1));

      // Reset mid-read: outputs return to reset values, no completion ever appears
      do_req(1'b0, 16'h0400, 64'h0, a);
      wait_tx_hs(h);
      @(posedge clk); #1;
      @(posedge clk); #1;
      nreset = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      @(negedge clk);
      chk("midrst_ready_back", 256'(req_ready), 256'(1));
      repeat (12) @(negedge clk);
      chk("midrst_no_rsp", 256'(rsp_q.size()), 256'(0));
      chk("final_tx_left", 256'(tx_q.size()), 256'(0));
      chk("final_tx_count", 256'(tx_count), 256'(6));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
